// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, register-file read port, MEM/WB bypass sources and execute.
// slave is the ID/EX stage; master is everything around it.
interface id_ex_operand_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             i_id_valid;
   logic             o_id_ready;
   logic [4:0]       i_id_rs1;
   logic [4:0]       i_id_rs2;
   logic [4:0]       i_id_rd;
   logic             i_id_use_rs1;
   logic             i_id_use_rs2;
   logic             i_id_rd_we;
   logic             i_id_is_load;
   logic [XLEN-1:0]  i_id_imm;
   logic [XLEN-1:0]  i_id_pc;
   logic [4:0]       o_rf_a1;
   logic [4:0]       o_rf_a2;
   logic [XLEN-1:0]  i_rf_rd1;
   logic [XLEN-1:0]  i_rf_rd2;
   logic             i_mem_valid;
   logic             i_mem_we;
   logic [4:0]       i_mem_rd;
   logic [XLEN-1:0]  i_mem_data;
   logic             i_wb_valid;
   logic             i_wb_we;
   logic [4:0]       i_wb_rd;
   logic [XLEN-1:0]  i_wb_data;
   logic             i_ex_ready;
   logic             i_flush;
   logic             o_ex_valid;
   logic [XLEN-1:0]  o_ex_rs1_val;
   logic [XLEN-1:0]  o_ex_rs2_val;
   logic [4:0]       o_ex_rd;
   logic [4:0]       o_ex_rs1;
   logic [4:0]       o_ex_rs2;
   logic             o_ex_rd_we;
   logic             o_ex_is_load;
   logic [XLEN-1:0]  o_ex_imm;
   logic [XLEN-1:0]  o_ex_pc;
   logic [CNT_W-1:0] o_lu_stall_cnt;

   modport slave (
      input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_use_rs1, i_id_use_rs2,
             i_id_rd_we, i_id_is_load, i_id_imm, i_id_pc, i_rf_rd1, i_rf_rd2,
             i_mem_valid, i_mem_we, i_mem_rd, i_mem_data,
             i_wb_valid, i_wb_we, i_wb_rd, i_wb_data, i_ex_ready, i_flush,
      output o_id_ready, o_rf_a1, o_rf_a2, o_ex_valid, o_ex_rs1_val, o_ex_rs2_val,
             o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_rd_we, o_ex_is_load, o_ex_imm, o_ex_pc,
             o_lu_stall_cnt
   );

   modport master (
      output i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_use_rs1, i_id_use_rs2,
             i_id_rd_we, i_id_is_load, i_id_imm, i_id_pc, i_rf_rd1, i_rf_rd2,
             i_mem_valid, i_mem_we, i_mem_rd, i_mem_data,
             i_wb_valid, i_wb_we, i_wb_rd, i_wb_data, i_ex_ready, i_flush,
      input  o_id_ready, o_rf_a1, o_rf_a2, o_ex_valid, o_ex_rs1_val, o_ex_rs2_val,
             o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_rd_we, o_ex_is_load, o_ex_imm, o_ex_pc,
             o_lu_stall_cnt
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register; operands resolved combinationally from 1-cycle RF data plus MEM/WB bypass.
// Holds while execute stalls; a load-use match inserts one bubble and drops o_id_ready.
module id_ex_operand_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic                i_clk,
   input logic                i_rst,
   id_ex_operand_stage_if.slave bus
);
   typedef struct packed {
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            rd_we;
      logic            is_load;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } ex_fields_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   ex_fields_t       ex_q;
   ex_fields_t       id_d;
   logic             ex_vld_q;
   logic [CNT_W-1:0] lu_cnt_q;
   logic             free;
   logic             hazard;
   logic             advance;
   logic             rs1_hit;
   logic             rs2_hit;
   logic             mem_fwd;
   logic             wb_fwd;

   always_comb begin
      id_d         = '0;
      id_d.rd      = bus.i_id_rd;
      id_d.rs1     = bus.i_id_rs1;
      id_d.rs2     = bus.i_id_rs2;
      id_d.rd_we   = bus.i_id_rd_we;
      id_d.is_load = bus.i_id_is_load;
      id_d.imm     = bus.i_id_imm;
      id_d.pc      = bus.i_id_pc;
   end

   assign free    = bus.i_ex_ready | ~ex_vld_q;
   assign rs1_hit = bus.i_id_use_rs1 & (bus.i_id_rs1 == ex_q.rd);
   assign rs2_hit = bus.i_id_use_rs2 & (bus.i_id_rs2 == ex_q.rd);
   assign hazard  = ex_vld_q & ex_q.is_load & ex_q.rd_we & (ex_q.rd != 5'd0)
                  & bus.i_id_valid & (rs1_hit | rs2_hit);
   assign advance = free & ~hazard & ~bus.i_flush;

   // Flushed decode instructions are consumed so decode never stalls on a kill.
   assign bus.o_id_ready = bus.i_flush | (free & ~hazard);

   // A held EX register keeps re-reading its own sources so writebacks land in rf data.
   assign bus.o_rf_a1 = advance ? bus.i_id_rs1 : ex_q.rs1;
   assign bus.o_rf_a2 = advance ? bus.i_id_rs2 : ex_q.rs2;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ex_vld_q <= 1'b0;
         ex_q     <= '0;
         lu_cnt_q <= '0;
      end else if (bus.i_flush) begin
         ex_vld_q <= 1'b0;
      end else if (free & hazard) begin
         ex_vld_q <= 1'b0;
         if (lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + CNT_ONE;
      end else if (advance) begin
         ex_q     <= id_d;
         ex_vld_q <= bus.i_id_valid;
      end
   end

   // MEM never carries load data here: the bubble keeps a consumer out of EX until the load is in WB.
   function automatic logic [XLEN-1:0] resolve(
      input logic [4:0]      idx,
      input logic [XLEN-1:0] rf_dat,
      input logic            mem_en,
      input logic [4:0]      mem_rd,
      input logic [XLEN-1:0] mem_dat,
      input logic            wb_en,
      input logic [4:0]      wb_rd,
      input logic [XLEN-1:0] wb_dat
   );
      logic [XLEN-1:0] val;
      val = rf_dat;
      if (idx == 5'd0)                     val = '0;
      else if (mem_en && (mem_rd == idx))  val = mem_dat;
      else if (wb_en && (wb_rd == idx))    val = wb_dat;
      return val;
   endfunction

   assign mem_fwd = bus.i_mem_valid & bus.i_mem_we;
   assign wb_fwd  = bus.i_wb_valid & bus.i_wb_we;

   assign bus.o_ex_rs1_val = resolve(ex_q.rs1, bus.i_rf_rd1, mem_fwd, bus.i_mem_rd, bus.i_mem_data,
                                     wb_fwd, bus.i_wb_rd, bus.i_wb_data);
   assign bus.o_ex_rs2_val = resolve(ex_q.rs2, bus.i_rf_rd2, mem_fwd, bus.i_mem_rd, bus.i_mem_data,
                                     wb_fwd, bus.i_wb_rd, bus.i_wb_data);

   assign bus.o_ex_valid     = ex_vld_q;
   assign bus.o_ex_rd        = ex_q.rd;
   assign bus.o_ex_rs1       = ex_q.rs1;
   assign bus.o_ex_rs2       = ex_q.rs2;
   assign bus.o_ex_rd_we     = ex_q.rd_we;
   assign bus.o_ex_is_load   = ex_q.is_load;
   assign bus.o_ex_imm       = ex_q.imm;
   assign bus.o_ex_pc        = ex_q.pc;
   assign bus.o_lu_stall_cnt = lu_cnt_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised and directed bench for id_ex_operand_stage against a behavioural pipeline-slot model.
module tb_id_ex_operand_stage;
   localparam int XLEN    = 32;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      bit              vld;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      bit              rd_we;
      bit              is_load;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } slot_t;

   logic i_clk;
   logic i_rst;

   id_ex_operand_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
   id_ex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   slot_t           m;
   int              cnt;
   logic [XLEN-1:0] regs [32];
   logic [XLEN-1:0] rf_q1, rf_q2;
   int              n_vec, n_err;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_hazard();
      bit reads_dest;
      reads_dest = (bus.i_id_use_rs1 && bus.i_id_rs1 == m.rd) || (bus.i_id_use_rs2 && bus.i_id_rs2 == m.rd);
      return m.vld && m.is_load && m.rd_we && (m.rd != 0) && bus.i_id_valid && reads_dest;
   endfunction

   function automatic bit exp_free();
      return !m.vld || bus.i_ex_ready;
   endfunction

   function automatic bit exp_advance();
      return exp_free() && !exp_hazard() && !bus.i_flush;
   endfunction

   function automatic logic [XLEN-1:0] exp_operand(input logic [4:0] idx, input logic [XLEN-1:0] rf);
      if (idx == 0) return '0;
      if (bus.i_mem_valid && bus.i_mem_we && bus.i_mem_rd == idx) return bus.i_mem_data;
      if (bus.i_wb_valid && bus.i_wb_we && bus.i_wb_rd == idx) return bus.i_wb_data;
      return rf;
   endfunction

   task automatic model_reset();
      m.vld = 0; m.rd = 0; m.rs1 = 0; m.rs2 = 0;
      m.rd_we = 0; m.is_load = 0; m.imm = 0; m.pc = 0;
      cnt = 0;
   endtask

   // Called on each rising edge before the bench changes any input.
   task automatic model_step();
      logic [4:0] a1, a2;
      bit adv, hz, fr;
      adv = exp_advance();
      hz  = exp_hazard();
      fr  = exp_free();
      a1  = adv ? bus.i_id_rs1 : m.rs1;
      a2  = adv ? bus.i_id_rs2 : m.rs2;
      rf_q1 = regs[a1];
      rf_q2 = regs[a2];
      if (bus.i_wb_valid && bus.i_wb_we && bus.i_wb_rd != 0) regs[bus.i_wb_rd] = bus.i_wb_data;
      if (!i_rst) model_reset();
      else if (bus.i_flush) m.vld = 0;
      else if (fr && hz) begin
         m.vld = 0;
         if (cnt < CNT_MAX) cnt++;
      end else if (adv) begin
         m.vld = bus.i_id_valid; m.rd = bus.i_id_rd; m.rs1 = bus.i_id_rs1; m.rs2 = bus.i_id_rs2;
         m.rd_we = bus.i_id_rd_we; m.is_load = bus.i_id_is_load; m.imm = bus.i_id_imm; m.pc = bus.i_id_pc;
      end
   endtask

   task automatic check_outputs();
      bit adv;
      adv = exp_advance();
      chk("ex_valid", bus.o_ex_valid, m.vld);
      chk("id_ready", bus.o_id_ready, bus.i_flush || (exp_free() && !exp_hazard()));
      chk("rf_a1", bus.o_rf_a1, adv ? bus.i_id_rs1 : m.rs1);
      chk("rf_a2", bus.o_rf_a2, adv ? bus.i_id_rs2 : m.rs2);
      chk("lu_cnt", bus.o_lu_stall_cnt, cnt);
      chk("ex_rd", bus.o_ex_rd, m.rd);
      chk("ex_rs1", bus.o_ex_rs1, m.rs1);
      chk("ex_rs2", bus.o_ex_rs2, m.rs2);
      chk("ex_rd_we", bus.o_ex_rd_we, m.rd_we);
      chk("ex_is_load", bus.o_ex_is_load, m.is_load);
      chk("ex_imm", bus.o_ex_imm, m.imm);
      chk("ex_pc", bus.o_ex_pc, m.pc);
      if (m.vld) begin
         chk("rs1_val", bus.o_ex_rs1_val, exp_operand(m.rs1, bus.i_rf_rd1));
         chk("rs2_val", bus.o_ex_rs2_val, exp_operand(m.rs2, bus.i_rf_rd2));
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_step();
      #1;
      bus.i_rf_rd1 = rf_q1;
      bus.i_rf_rd2 = rf_q2;
   endtask

   task automatic settle();
      @(negedge i_clk);
      check_outputs();
   endtask

   task automatic idle();
      bus.i_id_valid = 0; bus.i_id_rs1 = 0; bus.i_id_rs2 = 0; bus.i_id_rd = 0;
      bus.i_id_use_rs1 = 0; bus.i_id_use_rs2 = 0; bus.i_id_rd_we = 0; bus.i_id_is_load = 0;
      bus.i_id_imm = 0; bus.i_id_pc = 0;
      bus.i_mem_valid = 0; bus.i_mem_we = 0; bus.i_mem_rd = 0; bus.i_mem_data = 0;
      bus.i_wb_valid = 0; bus.i_wb_we = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0;
      bus.i_ex_ready = 1; bus.i_flush = 0;
   endtask

   task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input bit u1, input bit u2, input bit we, input bit ld, input logic [XLEN-1:0] imm);
      bus.i_id_valid = 1; bus.i_id_rs1 = rs1; bus.i_id_rs2 = rs2; bus.i_id_rd = rd;
      bus.i_id_use_rs1 = u1; bus.i_id_use_rs2 = u2; bus.i_id_rd_we = we; bus.i_id_is_load = ld;
      bus.i_id_imm = imm; bus.i_id_pc = $urandom;
   endtask

   task automatic rand_inputs();
      bus.i_id_valid   = ($urandom_range(0, 3) != 0);
      bus.i_id_rs1     = 5'($urandom_range(0, 3));
      bus.i_id_rs2     = 5'($urandom_range(0, 3));
      bus.i_id_rd      = 5'($urandom_range(0, 3));
      bus.i_id_use_rs1 = 1'($urandom);
      bus.i_id_use_rs2 = 1'($urandom);
      bus.i_id_rd_we   = ($urandom_range(0, 3) != 0);
      bus.i_id_is_load = 1'($urandom);
      bus.i_id_imm     = $urandom;
      bus.i_id_pc      = $urandom;
      bus.i_mem_valid  = 1'($urandom);
      bus.i_mem_we     = 1'($urandom);
      bus.i_mem_rd     = 5'($urandom_range(0, 3));
      bus.i_mem_data   = $urandom;
      bus.i_wb_valid   = 1'($urandom);
      bus.i_wb_we      = 1'($urandom);
      bus.i_wb_rd      = 5'($urandom_range(0, 3));
      bus.i_wb_data    = $urandom;
      bus.i_ex_ready   = ($urandom_range(0, 3) != 0);
      bus.i_flush      = ($urandom_range(0, 9) == 0);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      rf_q1 = 0; rf_q2 = 0;
      bus.i_rf_rd1 = 0; bus.i_rf_rd2 = 0;
      model_reset();
      i_rst = 0;
      idle();
      #2;
      chk("rst_ex_valid", bus.o_ex_valid, 0);
      chk("rst_cnt", bus.o_lu_stall_cnt, 0);
      chk("rst_ex_pc", bus.o_ex_pc, 0);
      check_outputs();

      // addi x5, x0, 7
      tick(); i_rst = 1; idle(); dec(5'd0, 5'd0, 5'd5, 1, 0, 1, 0, 32'd7); settle();
      chk("addi_id_ready", bus.o_id_ready, 1);
      tick(); idle(); bus.i_ex_ready = 0; settle();
      chk("addi_ex_valid", bus.o_ex_valid, 1);
      chk("addi_rs1_val", bus.o_ex_rs1_val, 0);
      chk("addi_imm", bus.o_ex_imm, 7);

      // Bypass priority on x3: MEM over WB over register file.
      regs[3] = 32'h33;
      tick(); idle(); dec(5'd3, 5'd0, 5'd7, 1, 0, 1, 0, 32'd0); settle();
      tick(); idle(); bus.i_ex_ready = 0;
      bus.i_mem_valid = 1; bus.i_mem_we = 1; bus.i_mem_rd = 3; bus.i_mem_data = 32'h11;
      bus.i_wb_valid = 1; bus.i_wb_we = 1; bus.i_wb_rd = 3; bus.i_wb_data = 32'h22;
      settle();
      chk("byp_mem", bus.o_ex_rs1_val, 32'h11);
      bus.i_mem_rd = 4; #1;
      chk("byp_wb", bus.o_ex_rs1_val, 32'h22);
      bus.i_wb_rd = 4; #1;
      chk("byp_rf", bus.o_ex_rs1_val, 32'h33);

      // No false hazard: load to x0, and an unused rs2 field matching the load's rd.
      tick(); idle(); dec(5'd1, 5'd0, 5'd0, 1, 0, 1, 1, 32'd0); settle();
      tick(); idle(); dec(5'd0, 5'd0, 5'd6, 1, 1, 1, 0, 32'd0); settle();
      chk("nofalse_x0_ready", bus.o_id_ready, 1);
      tick(); idle(); dec(5'd1, 5'd4, 5'd4, 1, 0, 1, 1, 32'd0); settle();
      tick(); idle(); dec(5'd2, 5'd4, 5'd7, 1, 0, 1, 0, 32'd0); settle();
      chk("nofalse_rs2_ready", bus.o_id_ready, 1);
      chk("nofalse_cnt", bus.o_lu_stall_cnt, 0);

      // lw x4 then add x6, x4, x1.
      tick(); idle(); dec(5'd1, 5'd0, 5'd4, 1, 0, 1, 1, 32'd0); settle();
      tick(); idle(); dec(5'd4, 5'd1, 5'd6, 1, 1, 1, 0, 32'd0); settle();
      chk("lu_id_ready", bus.o_id_ready, 0);
      tick(); idle(); dec(5'd4, 5'd1, 5'd6, 1, 1, 1, 0, 32'd0); settle();
      chk("lu_bubble", bus.o_ex_valid, 0);
      chk("lu_cnt", bus.o_lu_stall_cnt, 1);
      chk("lu_ready_after", bus.o_id_ready, 1);
      tick(); idle(); bus.i_ex_ready = 0;
      bus.i_wb_valid = 1; bus.i_wb_we = 1; bus.i_wb_rd = 4; bus.i_wb_data = 32'hDEAD;
      settle();
      chk("lu_add_valid", bus.o_ex_valid, 1);
      chk("lu_add_rs1", bus.o_ex_rs1_val, 32'hDEAD);

      // Downstream stall for three cycles with a WB write to the held source.
      tick(); idle(); dec(5'd2, 5'd0, 5'd8, 1, 0, 1, 0, 32'h55); settle();
      tick(); idle(); bus.i_ex_ready = 0;
      bus.i_wb_valid = 1; bus.i_wb_we = 1; bus.i_wb_rd = 2; bus.i_wb_data = 32'hBEEF;
      settle();
      chk("stall_a1", bus.o_rf_a1, 2);
      chk("stall_byp", bus.o_ex_rs1_val, 32'hBEEF);
      tick(); idle(); bus.i_ex_ready = 0; settle();
      chk("stall_imm", bus.o_ex_imm, 32'h55);
      tick(); idle(); bus.i_ex_ready = 0; settle();
      chk("stall_rf", bus.o_ex_rs1_val, 32'hBEEF);
      chk("stall_a1_late", bus.o_rf_a1, 2);

      // Flush coinciding with a load-use hazard.
      tick(); idle(); dec(5'd1, 5'd0, 5'd4, 1, 0, 1, 1, 32'd0); settle();
      tick(); idle(); dec(5'd4, 5'd0, 5'd9, 1, 0, 1, 0, 32'd0); bus.i_flush = 1; settle();
      chk("fl_id_ready", bus.o_id_ready, 1);
      tick(); idle(); settle();
      chk("fl_valid", bus.o_ex_valid, 0);
      chk("fl_cnt", bus.o_lu_stall_cnt, 1);

      // lw x4, 0(x4) repeatedly: one bubble every two cycles until the counter saturates.
      for (int k = 0; k < 2 * CNT_MAX + 8; k++) begin
         tick(); idle(); dec(5'd4, 5'd0, 5'd4, 1, 0, 1, 1, 32'd0); settle();
      end
      chk("sat_cnt", bus.o_lu_stall_cnt, CNT_MAX);

      for (int k = 0; k < 3000; k++) begin
         tick(); rand_inputs(); settle();
      end

      // Reset asserted between clock edges must clear state at once.
      tick(); rand_inputs(); #2;
      i_rst = 0; #1;
      chk("arst_valid", bus.o_ex_valid, 0);
      chk("arst_cnt", bus.o_lu_stall_cnt, 0);
      chk("arst_rd", bus.o_ex_rd, 0);
      model_reset();
      settle();
      tick(); i_rst = 1; rand_inputs(); settle();

      for (int k = 0; k < 500; k++) begin
         tick(); rand_inputs(); settle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline stage between decode and execute. It drives the register-file read addresses. The register file's registered read data returns one cycle later, and this stage resolves operand values from that data plus MEM/WB bypasses. It also detects load-use hazards, inserting one bubble and stalling decode.

Parameters:
XLEN, 32, datapath/operand width
CNT_W, 16, width of saturating load-use stall counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_id_valid  in  1  decode presents instruction
o_id_ready  out  1  stage accepts decode instruction this cycle
i_id_rs1, i_id_rs2, i_id_rd  in  5 each  register indices
i_id_use_rs1, i_id_use_rs2  in  1 each  instruction reads rs1/rs2
i_id_rd_we, i_id_is_load  in  1 each  writes rd / is load
i_id_imm, i_id_pc  in  XLEN each  immediate, PC
o_rf_a1, o_rf_a2  out  5 each  register-file read addresses (combinational)
i_rf_rd1, i_rf_rd2  in  XLEN each  register-file read data (registered, 1-cycle latency)
i_mem_valid, i_mem_we  in  1 each  MEM-stage instruction valid / writes rd
i_mem_rd  in  5  MEM destination
i_mem_data  in  XLEN  MEM result (non-load only)
i_wb_valid, i_wb_we  in  1 each  WB-stage valid / writes rd
i_wb_rd  in  5  WB destination
i_wb_data  in  XLEN  WB result
i_ex_ready  in  1  execute can accept
i_flush  in  1  kill EX-register contents and the decode instruction
o_ex_valid  out  1  EX register holds a valid instruction
o_ex_rs1_val, o_ex_rs2_val  out  XLEN each  resolved operands (combinational)
o_ex_rd, o_ex_rs1, o_ex_rs2  out  5 each  registered indices
o_ex_rd_we, o_ex_is_load  out  1 each  registered controls
o_ex_imm, o_ex_pc  out  XLEN each  registered
o_lu_stall_cnt  out  CNT_W  load-use bubble count, saturating

Behaviour:
- Reset (i_rst=0, async): o_ex_valid=0; all EX fields, including indices, imm and pc, are 0; o_lu_stall_cnt=0.
- free = i_ex_ready | ~o_ex_valid.
- hazard = o_ex_valid & o_ex_is_load & o_ex_rd_we & (o_ex_rd!=0) & i_id_valid & ((i_id_use_rs1 & i_id_rs1==o_ex_rd) | (i_id_use_rs2 & i_id_rs2==o_ex_rd)).
- advance = free & ~hazard & ~i_flush.
- o_id_ready = i_flush | (free & ~hazard). During flush, decode's instruction is consumed and dropped.
- o_rf_a1/a2 = advance ? i_id_rs1/rs2 : o_ex_rs1/rs2. When the EX register holds, the same registers are re-read every cycle, so later writebacks are picked up.
- Rising edge, priority order:
  - i_flush: o_ex_valid<=0.
  - Else if free & hazard: bubble (o_ex_valid<=0), increment counter; counter saturates at all-ones.
  - Else if advance: load all ID fields; o_ex_valid<=i_id_valid.
  - Else: hold.
- Operand resolution, per operand, combinational in the EX cycle. Index is o_ex_rs1 or o_ex_rs2. Priority order:
  - index==0: value 0.
  - i_mem_valid & i_mem_we & i_mem_rd==index: i_mem_data.
  - i_wb_valid & i_wb_we & i_wb_rd==index: i_wb_data.
  - Otherwise: i_rf_rdN.
- The WB bypass is mandatory: the register file samples its read address before a same-cycle WB write lands.
- A load in MEM is never forwarded from MEM. The hazard bubble guarantees the consumer reaches EX only once the load is in WB.
- Flush and hazard in the same cycle: flush wins and the counter does not increment.
- Reset mid-operation: state clears immediately, independent of clock.

Test Plan:
- Reset → o_ex_valid=0, o_lu_stall_cnt=0. Then `addi x5,x0,7` (rs1=0, imm=7) with i_ex_ready=1 → next cycle o_ex_valid=1, o_ex_rs1_val=0, o_ex_imm=7.
- EX/MEM bypass: producer writes x3=0x11 (MEM); WB writes x3=0x22 in the same cycle; consumer reads x3 in EX → o_ex_rs1_val=0x11. MEM not matching → 0x22. Neither matching, rf=0x33 → 0x33.
- Load-use: `lw x4` in EX, `add x6,x4,x1` at decode → o_id_ready=0 for one cycle, one bubble, counter=1. The add enters EX next cycle and takes x4 from WB (i_wb_data=0xDEAD) → o_ex_rs1_val=0xDEAD.
- No false hazard: load to x0, or a consumer with use_rs2=0 whose rs2 field matches the load's rd → no stall, counter stays 0.
- Downstream stall: i_ex_ready=0 for 3 cycles → EX fields held, o_rf_a1=o_ex_rs1. A WB write to that register during the stall shows in o_ex_rs1_val the same cycle (bypass) and later via rf.
- Flush during hazard → o_ex_valid=0 next cycle, o_id_ready=1, counter unchanged. Counter preset near max via 0xFFFF bubbles (CNT_W=16) → stays at 0xFFFF.
